// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses a combinational instruction memory and
// loads the IF/ID register. Handles stall, branch redirect/flush, halt and faults.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1024,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Halt,
  input  logic [31:0] Instruction,
  output logic [31:0] InstrAddr,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        Fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_BYTES);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    fault_d = fault_q;

    case (state_q)
      IDLE: state_d = RUN;

      RUN: begin
        if (Halt) begin
          instr_d = NOP_WORD;
          pcp4_d  = 32'd0;
          valid_d = 1'b0;
          state_d = HALTED;
        end else if (BranchTaken && (BranchTarget[1:0] != 2'b00)) begin
          fault_d = 1'b1;
          instr_d = NOP_WORD;
          pcp4_d  = 32'd0;
          valid_d = 1'b0;
          state_d = FAULT;
        end else if (BranchTaken) begin
          // Redirect discards the wrong-path word even while stalled.
          pc_d    = BranchTarget;
          instr_d = NOP_WORD;
          pcp4_d  = 32'd0;
          valid_d = 1'b0;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (pc_q >= PC_LIMIT) begin
          fault_d = 1'b1;
          instr_d = NOP_WORD;
          pcp4_d  = 32'd0;
          valid_d = 1'b0;
          state_d = FAULT;
        end else begin
          instr_d = Instruction;
          pcp4_d  = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end
      end

      HALTED, FAULT: begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  assign InstrAddr     = pc_q;
  assign IF_ID_Instr   = instr_q;
  assign IF_ID_PCPlus4 = pcp4_q;
  assign IF_ID_Valid   = valid_q;
  assign Fault         = fault_q;

endmodule
